// File: rtl/dm_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dm_store_buffer: posted-store FIFO between MEM stage and data-memory port |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [1:0]        st_type,
  input  logic [31:0]       st_pc,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  output logic              st_ready,
  output logic              st_misalign,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  output logic              ld_stall,
  input  logic              drain_en,
  output logic              MemWrite,
  output logic [31:0]       PC,
  output logic [31:0]       addr,
  output logic [31:0]       writeData,
  output logic [3:0]        byte_select,
  output logic              empty,
  output logic [PTR_W:0]    count
);

  localparam logic [1:0]       c_SB        = 2'b01;
  localparam logic [1:0]       c_SH        = 2'b10;
  localparam logic [1:0]       c_SW        = 2'b11;
  localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   c_CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   c_CNT_FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic [31:0]      c_WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0]      r_pc_q   [DEPTH];
  logic [31:0]      r_addr_q [DEPTH];
  logic [31:0]      r_data_q [DEPTH];
  logic [3:0]       r_be_q   [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_aligned;
  logic [3:0]       w_be;
  logic             w_req;
  logic             w_push;
  logic             w_pop;
  logic             w_misal;
  logic [DEPTH-1:0] w_hit;
  logic             w_out_hit;

  always_comb begin
    w_aligned = 1'b1;
    w_be      = 4'b0000;
    case (st_type)
      c_SB: w_be = 4'b0001 << st_addr[1:0];
      c_SH: begin
        w_aligned = ~st_addr[0];
        w_be      = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      c_SW: begin
        w_aligned = (st_addr[1:0] == 2'b00);
        w_be      = 4'b1111;
      end
      default: ;
    endcase
  end

  assign st_ready = (r_count != c_CNT_FULL);
  assign w_req    = st_valid & (st_type != 2'b00);
  assign w_push   = w_req & st_ready & w_aligned;
  // Misalignment is flagged regardless of fullness so the pipeline can trap early.
  assign w_misal  = w_req & ~w_aligned;
  assign w_pop    = drain_en & (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]   <= st_pc;
      r_addr_q[r_wr_ptr] <= st_addr;
      r_data_q[r_wr_ptr] <= st_data;
      r_be_q[r_wr_ptr]   <= w_be;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_wr_ptr == PTR_W'(i))) begin
          r_vld[i] <= 1'b1;
        end else if (w_pop && (r_rd_ptr == PTR_W'(i))) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MemWrite    <= 1'b0;
      PC          <= '0;
      addr        <= '0;
      writeData   <= '0;
      byte_select <= '0;
      st_misalign <= 1'b0;
    end else begin
      st_misalign <= w_misal;
      MemWrite    <= w_pop;
      if (w_pop) begin
        PC          <= r_pc_q[r_rd_ptr];
        addr        <= r_addr_q[r_rd_ptr];
        writeData   <= r_data_q[r_rd_ptr];
        byte_select <= r_be_q[r_rd_ptr];
      end
    end
  end

  // Word-granular match; the store being pushed this cycle is deliberately excluded.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign w_hit[i] = r_vld[i] & ~|((ld_addr ^ r_addr_q[i]) & c_WORD_MASK);
  end

  assign w_out_hit = MemWrite & ~|((ld_addr ^ addr) & c_WORD_MASK);
  assign ld_stall  = ld_valid & ((|w_hit) | w_out_hit);
  assign empty     = (r_count == '0) & ~MemWrite;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none
// Testbench for dm_store_buffer: directed scenarios plus random traffic against a queue model.
module tb_dm_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [1:0]  st_type;
  logic [31:0] st_pc, st_addr, st_data;
  logic        st_ready, st_misalign;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        drain_en;
  logic        MemWrite;
  logic [31:0] PC, addr, writeData;
  logic [3:0]  byte_select;
  logic        empty;
  logic [PTR_W:0] count;

  dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_type(st_type), .st_pc(st_pc), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_misalign(st_misalign),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .drain_en(drain_en), .MemWrite(MemWrite), .PC(PC), .addr(addr), .writeData(writeData),
    .byte_select(byte_select), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } st_t;

  st_t  m_q[$];
  st_t  m_out;
  logic m_mw;
  logic m_mis;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  function automatic logic m_aligned(input logic [1:0] t, input logic [31:0] a);
    if (t == 2'b10) return (a % 2) == 0;
    if (t == 2'b11) return (a % 4) == 0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_lanes(input logic [1:0] t, input logic [31:0] a);
    case (t)
      2'b01:   return 4'(1 << (a % 4));
      2'b10:   return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic m_stall(input logic lv, input logic [31:0] la);
    logic hit = 1'b0;
    foreach (m_q[i]) if ((m_q[i].a / 4) == (la / 4)) hit = 1'b1;
    if (m_mw && ((m_out.a / 4) == (la / 4))) hit = 1'b1;
    return lv && hit;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_mw  = 1'b0;
    m_mis = 1'b0;
    m_out = '{pc: 32'h0, a: 32'h0, d: 32'h0, be: 4'h0};
  endtask

  task automatic check_outputs();
    check("st_ready",    {31'b0, st_ready},    {31'b0, (m_q.size() < DEPTH)});
    check("st_misalign", {31'b0, st_misalign}, {31'b0, m_mis});
    check("ld_stall",    {31'b0, ld_stall},    {31'b0, m_stall(ld_valid, ld_addr)});
    check("empty",       {31'b0, empty},       {31'b0, (m_q.size() == 0) && !m_mw});
    check("count",       32'(count),           32'(m_q.size()));
    check("MemWrite",    {31'b0, MemWrite},    {31'b0, m_mw});
    check("PC",          PC,                   m_out.pc);
    check("addr",        addr,                 m_out.a);
    check("writeData",   writeData,            m_out.d);
    check("byte_select", 32'(byte_select),     32'(m_out.be));
  endtask

  // Applies the effect of the coming clock edge to the model.
  task automatic model_edge();
    bit ready = (m_q.size() < DEPTH);
    bit req   = st_valid && (st_type != 2'b00);
    m_mis = req && !m_aligned(st_type, st_addr);
    if (drain_en && m_q.size() > 0) begin
      m_out = m_q.pop_front();
      m_mw  = 1'b1;
    end else begin
      m_mw = 1'b0;
    end
    if (req && ready && m_aligned(st_type, st_addr))
      m_q.push_back('{pc: st_pc, a: st_addr, d: st_data, be: m_lanes(st_type, st_addr)});
  endtask

  task automatic step(input logic v, input logic [1:0] t, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] d, input logic lv, input logic [31:0] la, input logic de);
    @(negedge clk);
    st_valid = v; st_type = t; st_pc = pc; st_addr = a; st_data = d;
    ld_valid = lv; ld_addr = la; drain_en = de;
    #1;
    check_outputs();
    model_edge();
  endtask

  task automatic idle(input logic de);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, de);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    st_valid = 0; st_type = 0; st_pc = 0; st_addr = 0; st_data = 0;
    ld_valid = 0; ld_addr = 0; drain_en = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Single word store
    step(1, 2'b11, 32'h3000, 32'h10, 32'h1234_5678, 0, 0, 1);
    idle(1); settle();
    check("sw_mw",   {31'b0, MemWrite}, 32'd1);
    check("sw_addr", addr,              32'h10);
    check("sw_data", writeData,         32'h1234_5678);
    check("sw_pc",   PC,                32'h3000);
    check("sw_be",   32'(byte_select),  32'hF);
    idle(1); settle();
    check("sw_mw_low", {31'b0, MemWrite}, 32'd0);
    check("sw_empty",  {31'b0, empty},    32'd1);

    // Lane generation
    step(1, 2'b01, 32'h3004, 32'h23, 32'hAABB_CCDD, 0, 0, 1);
    step(1, 2'b10, 32'h3008, 32'h26, 32'h1122_3344, 0, 0, 1); settle();
    check("sb_be", 32'(byte_select), 32'h8);
    idle(1); settle();
    check("sh_be", 32'(byte_select), 32'hC);
    check("sh_mw", {31'b0, MemWrite}, 32'd1);
    idle(1);

    // Misaligned drops
    step(1, 2'b11, 32'h300C, 32'h12, 32'h5, 0, 0, 1); settle();
    check("mis_sw", {31'b0, st_misalign}, 32'd1);
    check("mis_sw_cnt", 32'(count), 32'd0);
    step(1, 2'b10, 32'h3010, 32'h11, 32'h6, 0, 0, 1); settle();
    check("mis_sh", {31'b0, st_misalign}, 32'd1);
    check("mis_sh_mw", {31'b0, MemWrite}, 32'd0);
    idle(1); idle(1);

    // Fill, refuse a fifth, then push while draining across wrap
    for (int i = 0; i < 4; i++) step(1, 2'b11, 32'h4000 + 4 * i, 32'h100 + 4 * i, 32'hA0 + i, 0, 0, 0);
    settle();
    check("full_cnt",   32'(count),           32'd4);
    check("full_ready", {31'b0, st_ready},    32'd0);
    step(1, 2'b11, 32'h4010, 32'h110, 32'hA4, 0, 0, 0); settle();
    check("full_ignore", 32'(count), 32'd4);
    for (int i = 0; i < 10; i++) step(1, 2'b11, 32'h5000 + 4 * i, 32'h200 + 4 * i, 32'hB0 + i, 0, 0, 1);
    repeat (6) idle(1);

    // Load hazard
    step(1, 2'b11, 32'h6000, 32'h40, 32'hDEAD_BEEF, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 1, 32'h42, 0);
    check("haz_hit", {31'b0, ld_stall}, 32'd1);
    step(0, 2'b00, 0, 0, 0, 1, 32'h44, 0);
    check("haz_miss", {31'b0, ld_stall}, 32'd0);
    step(0, 2'b00, 0, 0, 0, 1, 32'h40, 1);
    step(0, 2'b00, 0, 0, 0, 1, 32'h40, 1);
    check("haz_out", {31'b0, ld_stall}, 32'd1);
    step(0, 2'b00, 0, 0, 0, 1, 32'h40, 1);
    check("haz_clear", {31'b0, ld_stall}, 32'd0);

    // Asynchronous reset with stores pending and a write in flight
    for (int i = 0; i < 4; i++) step(1, 2'b11, 32'h7000 + 4 * i, 32'h300 + 4 * i, 32'hC0 + i, 0, 0, 0);
    idle(1); settle();
    #2 reset = 1'b1;
    #1;
    check("rst_mw",    {31'b0, MemWrite}, 32'd0);
    check("rst_cnt",   32'(count),        32'd0);
    check("rst_empty", {31'b0, empty},    32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) idle(1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [1:0]  t  = 2'($urandom_range(0, 3));
      logic [31:0] a  = 32'($urandom_range(0, 63));
      logic [31:0] la = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (t == 2'b11) a = a & 32'hFFFF_FFFC;
        if (t == 2'b10) a = a & 32'hFFFF_FFFE;
      end
      step(1'($urandom_range(0, 1)), t, $urandom, a, $urandom,
           1'($urandom_range(0, 1)), la, ($urandom_range(0, 9) < 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
